// File: rtl/adder_arb_pkg.sv
// Shared types and seven-segment constants for the adder request arbiter.
// Used by adder_req_arbiter and seg7_encode.
package adder_arb_pkg;

   localparam logic [7:0] SEG_0   = 8'h3f;
   localparam logic [7:0] SEG_1   = 8'h06;
   localparam logic [7:0] SEG_2   = 8'h5b;
   localparam logic [7:0] SEG_3   = 8'h4f;
   localparam logic [7:0] SEG_4   = 8'h66;
   localparam logic [7:0] SEG_5   = 8'h6d;
   localparam logic [7:0] SEG_6   = 8'h7d;
   localparam logic [7:0] SEG_7   = 8'h07;
   localparam logic [7:0] SEG_8   = 8'h7f;
   localparam logic [7:0] SEG_9   = 8'h67;
   localparam logic [7:0] SEG_ERR = 8'h80;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational sum-to-seven-segment lookup; sums above 9 light
// only the error dot.
module seg7_encode
   import adder_arb_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] i_sum,
   output logic [7:0]   o_seg
);

   logic [31:0] w_val;

   assign w_val = 32'(i_sum);

   always_comb begin
      o_seg = SEG_ERR;
      case (w_val)
         32'd0:   o_seg = SEG_0;
         32'd1:   o_seg = SEG_1;
         32'd2:   o_seg = SEG_2;
         32'd3:   o_seg = SEG_3;
         32'd4:   o_seg = SEG_4;
         32'd5:   o_seg = SEG_5;
         32'd6:   o_seg = SEG_6;
         32'd7:   o_seg = SEG_7;
         32'd8:   o_seg = SEG_8;
         32'd9:   o_seg = SEG_9;
         default: o_seg = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/adder_req_arbiter.sv
// Round-robin front end for a shared adder with a one-entry result buffer.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module adder_req_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int OPW  = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_a,
   input  logic [NREQ*OPW-1:0] req_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [OPW:0]        res_sum,
   output logic [IDW-1:0]      res_id,
   output logic [7:0]          res_seg,
   output logic [7:0]          res_count
);

   buf_state_t     r_state;
   buf_state_t     w_state_nxt;
   logic [IDW-1:0] w_ptr;
   logic [IDW-1:0] w_gnt;
   logic           w_found;
   logic           w_can;
   logic           w_acc;
   int             w_idx;
   logic [OPW-1:0] w_a;
   logic [OPW-1:0] w_b;
   logic [OPW:0]   w_sum;
   logic [7:0]     w_seg;
   logic [OPW:0]   r_sum;
   logic [IDW-1:0] r_id;
   logic [7:0]     r_seg;
   logic [7:0]     r_cnt;

`ifdef ADDER_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] w_ptr_nxt;

   assign w_ptr     = r_ptr;
   assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_acc) begin
         r_ptr <= w_ptr_nxt;
      end
   end
`endif

   // Scan downward so the candidate closest to the pointer wins.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = (int'(w_ptr) + k) % NREQ;
         if (req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = IDW'(w_idx);
         end
      end
   end

   assign w_can     = (r_state == EMPTY) || res_ready;
   assign w_acc     = w_can && w_found && !rst;
   assign req_ready = w_acc ? (NREQ'(1) << w_gnt) : '0;

   assign w_a   = req_a[w_gnt*OPW +: OPW];
   assign w_b   = req_b[w_gnt*OPW +: OPW];
   assign w_sum = (OPW+1)'(w_a) + (OPW+1)'(w_b);

   seg7_encode #(
      .W (OPW + 1)
   ) u_seg (
      .i_sum (w_sum),
      .o_seg (w_seg)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         EMPTY: if (w_acc) w_state_nxt = FULL;
         FULL:  if (res_ready && !w_acc) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
         r_sum   <= '0;
         r_id    <= '0;
         r_seg   <= SEG_0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_sum <= w_sum;
            r_id  <= w_gnt;
            r_seg <= w_seg;
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign res_valid = (r_state == FULL);
   assign res_sum   = r_sum;
   assign res_id    = r_id;
   assign res_seg   = r_seg;
   assign res_count = r_cnt;

endmodule

// File: tb/tb_adder_req_arbiter.sv
// Randomized bench for adder_req_arbiter against a queue-free
// behavioural model of the arbiter and result buffer.
module tb_adder_req_arbiter;

   localparam int NREQ = 4;
   localparam int OPW  = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*OPW-1:0] req_a;
   logic [NREQ*OPW-1:0] req_b;
   logic                res_valid;
   logic                res_ready;
   logic [OPW:0]        res_sum;
   logic [IDW-1:0]      res_id;
   logic [7:0]          res_seg;
   logic [7:0]          res_count;

   adder_req_arbiter #(
      .NREQ (NREQ),
      .OPW  (OPW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_id    (res_id),
      .res_seg   (res_seg),
      .res_count (res_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   bit             pend [NREQ];
   logic [OPW-1:0] op_a [NREQ];
   logic [OPW-1:0] op_b [NREQ];

   bit m_full;
   int m_sum;
   int m_id;
   int m_cnt;
   int m_ptr;

   logic [7:0] seg_tbl [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66,
                                8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h67};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input int s);
      return (s <= 9) ? seg_tbl[s] : 8'h80;
   endfunction

   function automatic int find_grant();
      int p;
`ifdef ADDER_ARB_FIXED_PRIO_EN
      p = 0;
`else
      p = m_ptr;
`endif
      for (int k = 0; k < NREQ; k++)
         if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_sum = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]            = pend[i];
         req_a[i*OPW +: OPW]     = op_a[i];
         req_b[i*OPW +: OPW]     = op_b[i];
      end
   endtask

   task automatic refill(input int pct);
      for (int i = 0; i < NREQ; i++)
         if (!pend[i] && ($urandom_range(99) < pct)) begin
            pend[i] = 1;
            op_a[i] = OPW'($urandom);
            op_b[i] = OPW'($urandom);
         end
   endtask

   task automatic step();
      int              g;
      bit              can;
      logic [NREQ-1:0] er;
      apply();
      #2;
      g   = find_grant();
      can = !m_full || res_ready;
      er  = '0;
      if (can && g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("res_valid", 32'(res_valid), 32'(m_full));
      chk("res_sum",   32'(res_sum),   32'(m_sum));
      chk("res_id",    32'(res_id),    32'(m_id));
      chk("res_seg",   32'(res_seg),   32'(seg_of(m_sum)));
      chk("res_count", 32'(res_count), 32'(m_cnt));
      @(posedge clk);
      #1;
      if (can && g >= 0) begin
         m_full  = 1;
         m_sum   = int'(op_a[g]) + int'(op_b[g]);
         m_id    = g;
         m_cnt   = (m_cnt + 1) % 256;
         m_ptr   = (g + 1) % NREQ;
         pend[g] = 0;
      end else if (m_full && res_ready) begin
         m_full = 0;
      end
   endtask

   task automatic reset_dut();
      rst = 1;
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      apply();
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic drain();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      res_ready = 1;
      step();
      step();
   endtask

   initial begin
      rst       = 1;
      res_ready = 1;
      model_reset();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1;
         op_a[i] = OPW'(i);
         op_b[i] = OPW'(i + 1);
      end
      apply();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(res_valid), 32'h0);
      chk("rst_seg",   32'(res_seg),   32'h3f);
      chk("rst_count", 32'(res_count), 32'h0);
      rst = 0;

      for (int k = 0; k < 8; k++) begin
         refill(100);
         step();
`ifdef ADDER_ARB_FIXED_PRIO_EN
         chk("rr_id", 32'(res_id), 32'h0);
`else
         chk("rr_id", 32'(res_id), 32'(k % NREQ));
`endif
         chk("rr_valid", 32'(res_valid), 32'h1);
      end

      drain();
      pend[2] = 1; op_a[2] = 4'd3; op_b[2] = 4'd4;
      step();
      chk("single_sum", 32'(res_sum), 32'd7);
      chk("single_id",  32'(res_id),  32'd2);
      chk("single_seg", 32'(res_seg), 32'h07);

      refill(100);
      res_ready = 0;
      for (int k = 0; k < 5; k++) step();
      chk("bp_sum", 32'(res_sum), 32'd7);
      res_ready = 1;
      step();
      chk("bp_refill_valid", 32'(res_valid), 32'h1);

      drain();
      pend[1] = 1; op_a[1] = 4'd15; op_b[1] = 4'd15;
      step();
      chk("ovf_sum", 32'(res_sum), 32'd30);
      chk("ovf_seg", 32'(res_seg), 32'h80);
      pend[3] = 1; op_a[3] = 4'd9; op_b[3] = 4'd0;
      step();
      chk("nine_seg", 32'(res_seg), 32'h67);

      reset_dut();
      for (int k = 0; k < 256; k++) begin
         refill(100);
         step();
      end
      chk("cnt_wrap", 32'(res_count), 32'h0);
      chk("wrap_full", 32'(res_valid), 32'h1);

      #1;
      rst = 1;
      #1;
      chk("async_valid", 32'(res_valid), 32'h0);
      chk("async_ready", 32'(req_ready), 32'h0);
      chk("async_seg",   32'(res_seg),   32'h3f);
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;

      for (int k = 0; k < 400; k++) begin
         res_ready = ($urandom_range(3) != 0);
         refill(50);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
